// File: rtl/pool_defs.sv
// rtl/pool_defs.sv - shared constants and helpers for the pooling stage
package pool_defs;

  localparam int MODE_MAX   = 0;
  localparam int MODE_AVG   = 1;
  localparam int PP_DEFAULT = 8;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/pool_line_buffer.sv
// rtl/pool_line_buffer.sv - ROWS x DIM store of per-column row reductions
// Slot wptr holds the oldest row and is overwritten by the row in flight.
module pool_line_buffer #(
  parameter int DIM  = 28,
  parameter int ROWS = 1,
  parameter int W    = 13,
  parameter int AW   = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic          row_done,
  input  logic [AW-1:0] addr,
  input  logic [W-1:0]  wdata,
  output logic [W-1:0]  rdata [ROWS]
);

  localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;

  logic [W-1:0]  mem [ROWS][DIM];
  logic [PW-1:0] wptr;

  always_ff @(posedge clk) begin
    if (!reset) begin
      wptr <= '0;
    end else if (row_done) begin
      wptr <= (wptr == PW'(ROWS - 1)) ? '0 : wptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int r = 0; r < ROWS; r++) begin
        if (wptr == PW'(r)) mem[r][addr] <= wdata;
      end
    end
  end

  always_comb begin
    for (int r = 0; r < ROWS; r++) rdata[r] = mem[r][addr];
  end

endmodule

// File: rtl/pool2d_stream.sv
// rtl/pool2d_stream.sv - streaming KxK max / floor-average pooling stage
module pool2d_stream
  import pool_defs::*;
#(
  parameter int DIM    = 28,
  parameter int K      = 2,
  parameter int STRIDE = 2,
  parameter int PP     = PP_DEFAULT,
  parameter int MODE   = MODE_MAX
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [PP:0] pxl_in,
  output logic [PP:0] pool_out,
  output logic        out_valid,
  output logic        frame_done
);

  localparam int LG = clog2(K);
  localparam int HW = PP + 1 + 2 * LG;
  localparam int OW = PP + 1;
  localparam int AW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam logic [5:0] LAST = 6'(DIM - 1);
  localparam logic [5:0] KM1  = 6'(K - 1);
  localparam logic [5:0] STEP = 6'(STRIDE);

  if (STRIDE < 1 || STRIDE > K) begin : g_bad_stride
    $error("pool2d_stream: STRIDE must lie in 1..K");
  end
  if (MODE == MODE_AVG && (K & (K - 1)) != 0) begin : g_bad_avg_k
    $error("pool2d_stream: average mode needs K to be a power of two");
  end

  logic [5:0]           row, col;
  logic signed [PP:0]   hsr [K-1];
  logic signed [HW-1:0] h, v;
  logic [HW-1:0]        rd [K-1];
  logic [PP:0]          result;
  logic                 win_ok, last_px, row_end;

  function automatic logic signed [HW-1:0] combine(input logic signed [HW-1:0] a,
                                                   input logic signed [HW-1:0] b);
    if (MODE == MODE_MAX) return (a > b) ? a : b;
    return a + b;
  endfunction

  function automatic logic signed [HW-1:0] ext(input logic signed [PP:0] p);
    return {{(HW - PP - 1){p[PP]}}, p};
  endfunction

  assign row_end = (col == LAST);
  assign last_px = (row == LAST) && row_end;
  assign win_ok  = (row >= KM1) && (col >= KM1) &&
                   ((row - KM1) % STEP == 6'd0) && ((col - KM1) % STEP == 6'd0);

  // Row reduction across the shift register, then column reduction over the buffered rows.
  always_comb begin
    h = ext($signed(pxl_in));
    for (int i = 0; i < K - 1; i++) h = combine(h, ext(hsr[i]));
    v = h;
    for (int i = 0; i < K - 1; i++) v = combine(v, $signed(rd[i]));
  end

  assign result = (MODE == MODE_MAX) ? v[PP:0] : OW'(v >>> (2 * LG));

  pool_line_buffer #(
    .DIM  (DIM),
    .ROWS (K - 1),
    .W    (HW),
    .AW   (AW)
  ) u_lbuf (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (in_valid),
    .row_done (in_valid && row_end),
    .addr     (col[AW-1:0]),
    .wdata    (h),
    .rdata    (rd)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      row        <= '0;
      col        <= '0;
      pool_out   <= '0;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      for (int i = 0; i < K - 1; i++) hsr[i] <= '0;
    end else begin
      out_valid  <= in_valid && win_ok;
      frame_done <= in_valid && last_px;
      if (in_valid) begin
        if (win_ok) pool_out <= result;
        hsr[0] <= $signed(pxl_in);
        for (int i = 1; i < K - 1; i++) hsr[i] <= (col == 6'd0) ? '0 : hsr[i-1];
        if (row_end) begin
          col <= '0;
          row <= (row == LAST) ? '0 : row + 6'd1;
        end else begin
          col <= col + 6'd1;
        end
      end
    end
  end

endmodule
